seq_alu: RTL

- Parametrised, handshaked successor to the team's 4-bit-operand ALU.
- Accepts one operation at a time over a valid/ready interface. Logic and add/sub ops complete in one cycle; multiply and divide run iteratively, one bit per cycle.
- Returns a registered 2*WIDTH result plus status flags over a second valid/ready interface.
- Sits between the pin-mux front end and the output register bank of the top-level tile.

---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_alu_if.sv | 34 +++
 rtl/seq_alu_iter.sv | 93 +++++++++
 rtl/seq_alu.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the sequential ALU.
//   op_e    - 3-bit operation code carried on the request bus
//   state_e - top-level control states
//   OP_W    - width of the operation code field
package seq_alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OpAnd   = 3'd0,
        OpOr    = 3'd1,
        OpXor   = 3'd2,
        OpAdd   = 3'd3,
        OpSub   = 3'd4,
        OpMul   = 3'd5,
        OpDiv   = 3'd6,
        OpPassA = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bus of the sequential ALU.
//   Request : in_valid, in_ready, op, a, b
//   Response: out_valid, out_ready, result, flag_zero, flag_carry, flag_ovf, flag_dbz
//   master - the requester/consumer side; slave - the ALU side.
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [OP_W-1:0]      op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 flag_zero;
    logic                 flag_carry;
    logic                 flag_ovf;
    logic                 flag_dbz;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_dbz
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_dbz
    );

endinterface

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: iterative unsigned multiply / restoring divide, one bit per cycle.
//   clk, rst   - clock, asynchronous active-high reset
//   start_i    - load operands and begin (is_div_i selects divide)
//   a_i, b_i   - operands (multiplier/dividend in a_i, multiplicand/divisor in b_i)
//   done_o     - high during the last iteration cycle; result_o is valid then
//   result_o   - product, or {remainder, quotient}
// hi_q/lo_q form one 2*WIDTH shift register for both operations; the final
// word leaves on the same cycle the last iteration is computed.
module seq_alu_iter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o
);

    logic             busy_q, busy_d;
    logic             is_div_q, is_div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;

    always_comb begin
        busy_d   = busy_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;

        // Multiply: add multiplicand into the high half when the multiplier LSB is set,
        // then shift the whole {carry, hi, lo} right by one.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_fits  = div_shift >= {1'b0, b_q};

        if (start_i) begin
            busy_d   = 1'b1;
            is_div_d = is_div_i;
            cnt_d    = CNT_W'(WIDTH);
            hi_d     = '0;
            lo_d     = a_i;
            b_d      = b_i;
        end else if (busy_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
            if (is_div_q) begin
                // Remainder stays below b, so the low WIDTH bits of the difference suffice.
                hi_d = div_fits ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_fits};
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
        end
    end

    assign done_o   = busy_q && (cnt_q == CNT_W'(1));
    assign result_o = {hi_d, lo_d};

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle logic/add/sub and iterative mul/div.
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - seq_alu_if slave: request (in_valid/in_ready/op/a/b) and
//          response (out_valid/out_ready/result/flags)
// The result and flags are written when the FSM enters DONE; out_valid follows
// one edge later, so single-cycle ops answer one edge after the accept edge and
// mul/div answer WIDTH+1 edges after it.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);

    localparam int unsigned RW = 2 * WIDTH;

    state_e          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [RW-1:0]   result_q;
    logic            zero_q, carry_q, ovf_q, dbz_q;

    op_e             op;
    logic            accept;
    logic            iter_start;
    logic            iter_done;
    logic [RW-1:0]   iter_result;

    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  diff;
    logic [RW-1:0]   sc_res;
    logic            sc_carry, sc_ovf, sc_dbz;

    assign op         = op_e'(bus.op);
    assign accept     = bus.in_valid && in_ready_q;
    assign iter_start = accept && ((op == OpMul) || ((op == OpDiv) && (bus.b != '0)));

    // Single-cycle datapath; only used when the op does not need the iterator.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dbz   = 1'b0;
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        diff     = {1'b0, bus.a} - {1'b0, bus.b};
        case (op)
            OpAnd:   sc_res[WIDTH-1:0] = bus.a & bus.b;
            OpOr:    sc_res[WIDTH-1:0] = bus.a | bus.b;
            OpXor:   sc_res[WIDTH-1:0] = bus.a ^ bus.b;
            OpAdd: begin
                sc_res[WIDTH-1:0] = sum[WIDTH-1:0];
                sc_carry          = sum[WIDTH];
                sc_ovf            = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                    (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpSub: begin
                sc_res[WIDTH-1:0] = diff[WIDTH-1:0];
                sc_carry          = diff[WIDTH];  // borrow, i.e. a < b
                sc_ovf            = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                    (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpDiv: begin
                // Only reached with b == 0: quotient saturates, remainder is a.
                sc_res = {bus.a, {WIDTH{1'b1}}};
                sc_dbz = 1'b1;
            end
            OpPassA: sc_res[WIDTH-1:0] = bus.a;
            default: sc_res = '0;
        endcase
    end

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (iter_start),
        .is_div_i (op == OpDiv),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (iter_start) begin
                            state_q <= StBusy;
                        end else begin
                            result_q <= sc_res;
                            zero_q   <= (sc_res == '0);
                            carry_q  <= sc_carry;
                            ovf_q    <= sc_ovf;
                            dbz_q    <= sc_dbz;
                            state_q  <= StDone;
                        end
                    end
                end
                StBusy: begin
                    if (iter_done) begin
                        result_q <= iter_result;
                        zero_q   <= (iter_result == '0);
                        carry_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        dbz_q    <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_ovf   = ovf_q;
    assign bus.flag_dbz   = dbz_q;

endmodule
